// File: rtl/dma_ctrl.sv
// Word-at-a-time DMA engine between an external memory request/response channel
// and a dcache DMA port. Loads copy memory into the dcache; stores copy the other way.
module dma_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   input  logic [23:0] cmd_mem_addr,
   input  logic [1:0]  cmd_slot,
   input  logic [10:0] cmd_cache_addr,
   input  logic [11:0] cmd_len,
   output logic        busy,
   output logic        done,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [23:0] mem_req_addr,
   output logic [17:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [17:0] mem_rsp_data,
   output logic [1:0]  dma_slot,
   output logic [10:0] dma_addr,
   output logic        dma_we,
   output logic [17:0] dma_dat_w,
   output logic        dma_re,
   input  logic [17:0] dma_dat_r,
   input  logic        dma_dcache_read_complete
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_REQ  = 3'd1,
      LD_WAIT = 3'd2,
      LD_WR   = 3'd3,
      ST_RD   = 3'd4,
      ST_WAIT = 3'd5,
      ST_REQ  = 3'd6
   } state_t;

   state_t      r_state;
   logic [23:0] r_mem_addr;
   logic [1:0]  r_slot;
   logic [10:0] r_cache_addr;
   logic [11:0] r_count;
   logic [17:0] r_data;
   logic        r_done;

   state_t      w_state_next;
   logic [23:0] w_mem_addr_next;
   logic [1:0]  w_slot_next;
   logic [10:0] w_cache_addr_next;
   logic [11:0] w_count_next;
   logic [17:0] w_data_next;
   logic        w_done_next;
   logic        w_last;

   assign w_last = (r_count == 12'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_mem_addr   <= 24'd0;
         r_slot       <= 2'd0;
         r_cache_addr <= 11'd0;
         r_count      <= 12'd0;
         r_data       <= 18'd0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_mem_addr   <= w_mem_addr_next;
         r_slot       <= w_slot_next;
         r_cache_addr <= w_cache_addr_next;
         r_count      <= w_count_next;
         r_data       <= w_data_next;
         r_done       <= w_done_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_mem_addr_next   = r_mem_addr;
      w_slot_next       = r_slot;
      w_cache_addr_next = r_cache_addr;
      w_count_next      = r_count;
      w_data_next       = r_data;
      w_done_next       = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_mem_addr_next   = cmd_mem_addr;
               w_slot_next       = cmd_slot;
               w_cache_addr_next = cmd_cache_addr;
               w_count_next      = cmd_len;
               // A zero-length command completes without leaving IDLE.
               if (cmd_len == 12'd0) begin
                  w_done_next = 1'b1;
               end else begin
                  w_state_next = cmd_dir ? ST_RD : LD_REQ;
               end
            end
         end
         LD_REQ: begin
            if (mem_req_ready) begin
               w_state_next = LD_WAIT;
            end
         end
         LD_WAIT: begin
            if (mem_rsp_valid) begin
               w_data_next  = mem_rsp_data;
               w_state_next = LD_WR;
            end
         end
         LD_WR: begin
            w_mem_addr_next   = r_mem_addr + 24'd1;
            w_cache_addr_next = r_cache_addr + 11'd1;
            w_count_next      = r_count - 12'd1;
            w_state_next      = w_last ? IDLE : LD_REQ;
            w_done_next       = w_last;
         end
         ST_RD: begin
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (dma_dcache_read_complete) begin
               w_data_next  = dma_dat_r;
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               w_mem_addr_next   = r_mem_addr + 24'd1;
               w_cache_addr_next = r_cache_addr + 11'd1;
               w_count_next      = r_count - 12'd1;
               w_state_next      = w_last ? IDLE : ST_RD;
               w_done_next       = w_last;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Outputs decode straight from registered state so reset clears them at once.
   assign busy          = (r_state != IDLE);
   assign cmd_ready     = (r_state == IDLE);
   assign done          = r_done;
   assign mem_req_valid = (r_state == LD_REQ) || (r_state == ST_REQ);
   assign mem_req_we    = (r_state == ST_REQ);
   assign mem_req_addr  = r_mem_addr;
   assign mem_req_wdata = r_data;
   assign dma_slot      = r_slot;
   assign dma_addr      = r_cache_addr;
   assign dma_we        = (r_state == LD_WR);
   assign dma_re        = (r_state == ST_RD);
   assign dma_dat_w     = r_data;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a zero/variable-wait memory model and a dcache model.
module tb_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [23:0] cmd_mem_addr = 24'd0;
   logic [1:0]  cmd_slot = 2'd0;
   logic [10:0] cmd_cache_addr = 11'd0;
   logic [11:0] cmd_len = 12'd0;
   logic        busy;
   logic        done;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic        mem_req_we;
   logic [23:0] mem_req_addr;
   logic [17:0] mem_req_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [17:0] mem_rsp_data = 18'd0;
   logic [1:0]  dma_slot;
   logic [10:0] dma_addr;
   logic        dma_we;
   logic [17:0] dma_dat_w;
   logic        dma_re;
   logic [17:0] dma_dat_r = 18'd0;
   logic        dma_dcache_read_complete = 1'b0;

   int errors = 0;
   int checks = 0;

   // Task-owned model controls
   logic [17:0] rsp_tab [0:255];
   logic [17:0] dc_rd [0:8191];
   int          stall_target = 0;
   bit          mute = 1'b0;

   // Model-owned state and logs
   logic [7:0]  rsp_rd = 8'd0;
   int          stall_done = 0;
   bit          pend = 1'b0;
   bit          rd_pend = 1'b0;
   logic [12:0] rd_idx = 13'd0;
   int          done_cnt = 0;
   int          both_cnt = 0;
   int          rd_cnt = 0;
   logic [42:0] mem_log[$];
   logic [42:0] stall_log[$];
   logic [30:0] wr_log[$];

   dma_ctrl dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .cmd_valid                (cmd_valid),
      .cmd_ready                (cmd_ready),
      .cmd_dir                  (cmd_dir),
      .cmd_mem_addr             (cmd_mem_addr),
      .cmd_slot                 (cmd_slot),
      .cmd_cache_addr           (cmd_cache_addr),
      .cmd_len                  (cmd_len),
      .busy                     (busy),
      .done                     (done),
      .mem_req_valid            (mem_req_valid),
      .mem_req_ready            (mem_req_ready),
      .mem_req_we               (mem_req_we),
      .mem_req_addr             (mem_req_addr),
      .mem_req_wdata            (mem_req_wdata),
      .mem_rsp_valid            (mem_rsp_valid),
      .mem_rsp_data             (mem_rsp_data),
      .dma_slot                 (dma_slot),
      .dma_addr                 (dma_addr),
      .dma_we                   (dma_we),
      .dma_dat_w                (dma_dat_w),
      .dma_re                   (dma_re),
      .dma_dat_r                (dma_dat_r),
      .dma_dcache_read_complete (dma_dcache_read_complete)
   );

   always #5 clk = ~clk;

   // Models act on the falling edge, away from the DUT's sampling edge.
   always @(negedge clk) begin
      mem_rsp_valid = 1'b0;
      dma_dcache_read_complete = 1'b0;
      if (pend && rst_n) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = rsp_tab[rsp_rd];
         rsp_rd        = rsp_rd + 8'd1;
      end
      pend = 1'b0;
      if (rd_pend && rst_n) begin
         dma_dcache_read_complete = 1'b1;
         dma_dat_r = dc_rd[rd_idx];
      end
      rd_pend = 1'b0;
      if (mem_req_valid) begin
         if (stall_done < stall_target) begin
            mem_req_ready = 1'b0;
            stall_done++;
            stall_log.push_back({mem_req_we, mem_req_addr, mem_req_wdata});
         end else begin
            mem_req_ready = 1'b1;
            mem_log.push_back({mem_req_we, mem_req_addr, mem_req_wdata});
            if (!mem_req_we && !mute) pend = 1'b1;
         end
      end else begin
         mem_req_ready = 1'b1;
      end
      if (dma_re) begin
         rd_pend = 1'b1;
         rd_idx  = {dma_slot, dma_addr};
         rd_cnt++;
      end
      if (dma_we) wr_log.push_back({dma_slot, dma_addr, dma_dat_w});
      if (dma_we && dma_re) both_cnt++;
      if (done) done_cnt++;
   end

   task automatic issue(input logic dir, input logic [23:0] ma, input logic [1:0] sl,
                        input logic [10:0] ca, input logic [11:0] len);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
      end
      cmd_dir = dir; cmd_mem_addr = ma; cmd_slot = sl; cmd_cache_addr = ca; cmd_len = len;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output int n);
      n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, mem_req_valid, mem_req_we, dma_we, dma_re, cmd_ready} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000001",
                  {busy, done, mem_req_valid, mem_req_we, dma_we, dma_re, cmd_ready});
      end
      checks++;
      if ({mem_req_addr, mem_req_wdata, dma_addr, dma_slot, dma_dat_w} !== 73'd0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h dma_addr=%h slot=%h dat_w=%h want 0",
                  mem_req_addr, mem_req_wdata, dma_addr, dma_slot, dma_dat_w);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release: busy/done=%b want 00", {busy, done});
      end
      $display("reset: done");
   endtask

   task automatic test_load;
      int w0, m0, d0, n;
      w0 = wr_log.size(); m0 = mem_log.size(); d0 = done_cnt;
      rsp_tab[rsp_rd] = 18'd3423;
      rsp_tab[rsp_rd + 8'd1] = 18'd1337;
      issue(1'b0, 24'h000100, 2'd2, 11'd0, 12'd2);
      wait_done(50, n);
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL load_latency: got %0d cycles want 6", n);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (wr_log.size() - w0 != 2) begin
         errors++;
         $display("FAIL load_wr_count: got %0d want 2", wr_log.size() - w0);
      end else begin
         checks++;
         if (wr_log[w0] !== {2'd2, 11'd0, 18'd3423} || wr_log[w0+1] !== {2'd2, 11'd1, 18'd1337}) begin
            errors++;
            $display("FAIL load_wr_data: got %h %h want %h %h", wr_log[w0], wr_log[w0+1],
                     {2'd2, 11'd0, 18'd3423}, {2'd2, 11'd1, 18'd1337});
         end
      end
      checks++;
      if (mem_log.size() - m0 != 2) begin
         errors++;
         $display("FAIL load_req_count: got %0d want 2", mem_log.size() - m0);
      end else begin
         checks++;
         if (mem_log[m0][42:18] !== {1'b0, 24'h000100} || mem_log[m0+1][42:18] !== {1'b0, 24'h000101}) begin
            errors++;
            $display("FAIL load_req_addr: got %h %h want 0000100 0000101",
                     mem_log[m0][42:18], mem_log[m0+1][42:18]);
         end
      end
      checks++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL load_done: pulses=%0d busy=%b want 1 0", done_cnt - d0, busy);
      end
      $display("load: len=2 cycles=%0d", n);
   endtask

   task automatic test_store;
      int w0, m0, d0, n;
      w0 = wr_log.size(); m0 = mem_log.size(); d0 = done_cnt;
      dc_rd[{2'd1, 11'd5}] = 18'h2ABCD;
      issue(1'b1, 24'h123456, 2'd1, 11'd5, 12'd1);
      wait_done(50, n);
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL store_latency: got %0d cycles want 3", n);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (mem_log.size() - m0 != 1) begin
         errors++;
         $display("FAIL store_req_count: got %0d want 1", mem_log.size() - m0);
      end else begin
         checks++;
         if (mem_log[m0] !== {1'b1, 24'h123456, 18'h2ABCD}) begin
            errors++;
            $display("FAIL store_req: got %h want %h", mem_log[m0], {1'b1, 24'h123456, 18'h2ABCD});
         end
      end
      checks++;
      if (wr_log.size() != w0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL store_side: dcache writes=%0d done=%0d want 0 1", wr_log.size() - w0, done_cnt - d0);
      end
      $display("store: len=1 cycles=%0d", n);
   endtask

   task automatic test_wrap;
      int w0, m0, n;
      w0 = wr_log.size(); m0 = mem_log.size();
      rsp_tab[rsp_rd] = 18'h11111;
      rsp_tab[rsp_rd + 8'd1] = 18'h22222;
      issue(1'b0, 24'hFFFFFF, 2'd3, 11'd2047, 12'd2);
      wait_done(50, n);
      repeat (2) @(negedge clk);
      checks++;
      if (wr_log.size() - w0 != 2) begin
         errors++;
         $display("FAIL wrap_wr_count: got %0d want 2", wr_log.size() - w0);
      end else begin
         checks++;
         if (wr_log[w0] !== {2'd3, 11'd2047, 18'h11111} || wr_log[w0+1] !== {2'd3, 11'd0, 18'h22222}) begin
            errors++;
            $display("FAIL wrap_cache: got %h %h want %h %h", wr_log[w0], wr_log[w0+1],
                     {2'd3, 11'd2047, 18'h11111}, {2'd3, 11'd0, 18'h22222});
         end
      end
      checks++;
      if (mem_log.size() - m0 != 2) begin
         errors++;
         $display("FAIL wrap_req_count: got %0d want 2", mem_log.size() - m0);
      end else begin
         checks++;
         if (mem_log[m0][41:18] !== 24'hFFFFFF || mem_log[m0+1][41:18] !== 24'h000000) begin
            errors++;
            $display("FAIL wrap_mem: got %h %h want ffffff 000000", mem_log[m0][41:18], mem_log[m0+1][41:18]);
         end
      end
      $display("wrap: cache 2047->0 mem ffffff->0");
   endtask

   task automatic test_stall;
      int s0, m0, w0, n;
      s0 = stall_log.size(); m0 = mem_log.size(); w0 = wr_log.size();
      stall_target = stall_target + 5;
      rsp_tab[rsp_rd] = 18'h3FFFF;
      issue(1'b0, 24'h00ABCD, 2'd0, 11'd100, 12'd1);
      wait_done(50, n);
      repeat (2) @(negedge clk);
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL stall_latency: got %0d cycles want 8", n);
      end
      checks++;
      if (stall_log.size() - s0 != 5) begin
         errors++;
         $display("FAIL stall_count: got %0d want 5", stall_log.size() - s0);
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (stall_log[s0+i][42:18] !== {1'b0, 24'h00ABCD} || stall_log[s0+i] !== stall_log[s0]) begin
               errors++;
               $display("FAIL stall_stable[%0d]: got %h want %h", i, stall_log[s0+i], stall_log[s0]);
            end
         end
      end
      checks++;
      if (mem_log.size() - m0 != 1 || wr_log.size() - w0 != 1) begin
         errors++;
         $display("FAIL stall_xfer: reqs=%0d writes=%0d want 1 1", mem_log.size() - m0, wr_log.size() - w0);
      end else begin
         checks++;
         if (wr_log[w0] !== {2'd0, 11'd100, 18'h3FFFF}) begin
            errors++;
            $display("FAIL stall_wr: got %h want %h", wr_log[w0], {2'd0, 11'd100, 18'h3FFFF});
         end
      end
      $display("stall: 5 wait cycles, cycles=%0d", n);
   endtask

   task automatic test_zero_len;
      int w0, m0, s0, r0, d0;
      w0 = wr_log.size(); m0 = mem_log.size(); s0 = stall_log.size(); r0 = rd_cnt; d0 = done_cnt;
      issue(1'b0, 24'h000400, 2'd1, 11'd9, 12'd0);
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL zero_done: done/busy=%b want 10", {done, busy});
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_pulse: done=%b want 0", done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_log.size() != w0 || mem_log.size() != m0 || stall_log.size() != s0 || rd_cnt != r0) begin
         errors++;
         $display("FAIL zero_access: we=%0d req=%0d re=%0d want 0 0 0",
                  wr_log.size() - w0, mem_log.size() + stall_log.size() - m0 - s0, rd_cnt - r0);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL zero_pulses: got %0d want 1", done_cnt - d0);
      end
      $display("zero_len: done after accept");
   endtask

   task automatic test_reset_mid;
      int m0, d0, n;
      m0 = mem_log.size();
      mute = 1'b1;
      issue(1'b0, 24'h000200, 2'd1, 11'd7, 12'd1);
      for (int i = 0; i < 10; i++) begin
         if (mem_log.size() > m0) break;
         @(negedge clk);
      end
      @(negedge clk);
      d0 = done_cnt;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: busy=%b want 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_req_valid, mem_req_we, dma_we, dma_re, cmd_ready} !== 7'b0000001) begin
         errors++;
         $display("FAIL mid_reset_ctrl: got %b want 0000001",
                  {busy, done, mem_req_valid, mem_req_we, dma_we, dma_re, cmd_ready});
      end
      checks++;
      if ({mem_req_addr, dma_addr, dma_slot} !== 37'd0) begin
         errors++;
         $display("FAIL mid_reset_addr: addr=%h dma_addr=%h slot=%h want 0", mem_req_addr, dma_addr, dma_slot);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      mute = 1'b0;
      m0 = mem_log.size();
      dc_rd[{2'd1, 11'd7}] = 18'h15555;
      issue(1'b1, 24'h000300, 2'd1, 11'd7, 12'd1);
      wait_done(50, n);
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL mid_done: pulses=%0d want 1", done_cnt - d0);
      end
      checks++;
      if (mem_log.size() - m0 != 1) begin
         errors++;
         $display("FAIL mid_new_count: got %0d want 1", mem_log.size() - m0);
      end else begin
         checks++;
         if (mem_log[m0] !== {1'b1, 24'h000300, 18'h15555}) begin
            errors++;
            $display("FAIL mid_new_req: got %h want %h", mem_log[m0], {1'b1, 24'h000300, 18'h15555});
         end
      end
      $display("reset_mid: abandoned, new store ok");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_load;
      test_store;
      test_wrap;
      test_stall;
      test_zero_len;
      test_reset_mid;
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("FAIL we_re_overlap: got %0d cycles want 0", both_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
